// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM state encoding and the control-vector
// layout that the pipeline registers (including ID/EX) index by name.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LU   = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  localparam int CTL_W            = 5;
  localparam int CTL_PC_WE        = 0;
  localparam int CTL_IF_ID_WE     = 1;
  localparam int CTL_IF_ID_FLUSH  = 2;
  localparam int CTL_ID_EX_BUBBLE = 3;
  localparam int CTL_EX_MEM_WE    = 4;

  // All stages advance, nothing flushed or bubbled.
  localparam logic [CTL_W-1:0] CTL_DEFAULT = 5'b10011;

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard control: turns load-use, redirect and memory-busy events into pipeline
// register enables/flushes, with a one-shot load-use FSM, memory-wait timeout and stats.
module hazard_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int MEM_WAIT_MAX = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use_i,
  input  logic             branch_taken_i,
  input  logic             mem_busy_i,
  output logic             pc_we_o,
  output logic             if_id_we_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             ex_mem_we_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             timeout_err_o
);

  localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_WAIT_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

  state_e            state_q;
  state_e            state_d;
  logic [CTL_W-1:0]  ctl;
  logic              stall_inc;
  logic              flush_inc;
  logic [WAIT_W-1:0] wait_cnt_q;

  // Valid/ready style contract with the pipeline: a register advances only when its
  // write enable is 1 this cycle; flush/bubble replace its contents with a NOP instead.
  always_comb begin
    ctl       = CTL_DEFAULT;
    state_d   = ST_RUN;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (mem_busy_i) begin
      ctl     = '0;
      state_d = ST_WAIT;
    end else if (branch_taken_i) begin
      ctl       = '1;
      flush_inc = 1'b1;
    end else if (load_use_i && (state_q != ST_LU)) begin
      ctl                   = CTL_DEFAULT;
      ctl[CTL_PC_WE]        = 1'b0;
      ctl[CTL_IF_ID_WE]     = 1'b0;
      ctl[CTL_ID_EX_BUBBLE] = 1'b1;
      stall_inc             = 1'b1;
      state_d               = ST_LU;
    end
  end

  assign pc_we_o        = ctl[CTL_PC_WE];
  assign if_id_we_o     = ctl[CTL_IF_ID_WE];
  assign if_id_flush_o  = ctl[CTL_IF_ID_FLUSH];
  assign id_ex_bubble_o = ctl[CTL_ID_EX_BUBBLE];
  assign ex_mem_we_o    = ctl[CTL_EX_MEM_WE];
  assign state_o        = state_q;

  // wait_cnt counts consecutive busy cycles; the timeout fires on the edge that
  // registers the MEM_WAIT_MAX-th one and is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      timeout_err_o <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN, ST_LU, ST_WAIT: state_q <= state_d;
        default:                state_q <= ST_RUN;
      endcase
      if (mem_busy_i) begin
        if (wait_cnt_q != WAIT_MAX) wait_cnt_q <= wait_cnt_q + 1'b1;
        if (wait_cnt_q >= WAIT_LAST) timeout_err_o <= 1'b1;
      end else begin
        wait_cnt_q <= '0;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .count (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: a default-size and a small-parameter instance share
// inputs and are compared every cycle against an event-level reference model.
module tb_hazard_stall_ctrl;

  localparam int L_CNT_W = 16;
  localparam int L_WAIT  = 64;
  localparam int S_CNT_W = 2;
  localparam int S_WAIT  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_use_i = 1'b0;
  logic branch_taken_i = 1'b0;
  logic mem_busy_i = 1'b0;

  logic               l_pc_we, l_if_id_we, l_flush, l_bubble, l_ex_mem_we, l_timeout;
  logic [1:0]         l_state;
  logic [L_CNT_W-1:0] l_stall_cnt, l_flush_cnt;
  logic               s_pc_we, s_if_id_we, s_flush, s_bubble, s_ex_mem_we, s_timeout;
  logic [1:0]         s_state;
  logic [S_CNT_W-1:0] s_stall_cnt, s_flush_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: event-level bookkeeping
  bit last_was_stall;
  bit waiting;
  int busy_run;
  int stall_events;
  int flush_events;
  bit exp_pc, exp_ifid, exp_flush, exp_bubble, exp_exmem;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.CNT_W(L_CNT_W), .MEM_WAIT_MAX(L_WAIT)) dut_l (
    .clk(clk), .rst_n(rst_n), .load_use_i(load_use_i), .branch_taken_i(branch_taken_i),
    .mem_busy_i(mem_busy_i), .pc_we_o(l_pc_we), .if_id_we_o(l_if_id_we),
    .if_id_flush_o(l_flush), .id_ex_bubble_o(l_bubble), .ex_mem_we_o(l_ex_mem_we),
    .state_o(l_state), .stall_cnt_o(l_stall_cnt), .flush_cnt_o(l_flush_cnt),
    .timeout_err_o(l_timeout)
  );

  hazard_stall_ctrl #(.CNT_W(S_CNT_W), .MEM_WAIT_MAX(S_WAIT)) dut_s (
    .clk(clk), .rst_n(rst_n), .load_use_i(load_use_i), .branch_taken_i(branch_taken_i),
    .mem_busy_i(mem_busy_i), .pc_we_o(s_pc_we), .if_id_we_o(s_if_id_we),
    .if_id_flush_o(s_flush), .id_ex_bubble_o(s_bubble), .ex_mem_we_o(s_ex_mem_we),
    .state_o(s_state), .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt),
    .timeout_err_o(s_timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int top;
    top = (1 << w) - 1;
    return (v > top) ? top : v;
  endfunction

  task automatic model_reset();
    last_was_stall = 0;
    waiting        = 0;
    busy_run       = 0;
    stall_events   = 0;
    flush_events   = 0;
  endtask

  // Expected enables for the current inputs, from the priority rules.
  task automatic model_outputs();
    if (mem_busy_i) begin
      {exp_pc, exp_ifid, exp_flush, exp_bubble, exp_exmem} = 5'b00000;
    end else if (branch_taken_i) begin
      {exp_pc, exp_ifid, exp_flush, exp_bubble, exp_exmem} = 5'b11111;
    end else if (load_use_i && !last_was_stall) begin
      {exp_pc, exp_ifid, exp_flush, exp_bubble, exp_exmem} = 5'b00011;
    end else begin
      {exp_pc, exp_ifid, exp_flush, exp_bubble, exp_exmem} = 5'b11001;
    end
  endtask

  task automatic check_all();
    int exp_state;
    model_outputs();
    exp_state = waiting ? 2 : (last_was_stall ? 1 : 0);
    check("L ctl", {l_pc_we, l_if_id_we, l_flush, l_bubble, l_ex_mem_we},
          {exp_pc, exp_ifid, exp_flush, exp_bubble, exp_exmem});
    check("S ctl", {s_pc_we, s_if_id_we, s_flush, s_bubble, s_ex_mem_we},
          {exp_pc, exp_ifid, exp_flush, exp_bubble, exp_exmem});
    check("L state", l_state, exp_state);
    check("S state", s_state, exp_state);
    check("L stall_cnt", l_stall_cnt, sat(stall_events, L_CNT_W));
    check("S stall_cnt", s_stall_cnt, sat(stall_events, S_CNT_W));
    check("L flush_cnt", l_flush_cnt, sat(flush_events, L_CNT_W));
    check("S flush_cnt", s_flush_cnt, sat(flush_events, S_CNT_W));
    check("L timeout", l_timeout, (busy_run >= L_WAIT) ? 1 : 0);
    check("S timeout", s_timeout, (busy_run >= S_WAIT) ? 1 : 0);
  endtask

  // busy_run tracks the longest consecutive busy streak since reset (timeout is sticky).
  int cur_run;
  task automatic model_step();
    if (mem_busy_i) begin
      cur_run++;
      if (cur_run > busy_run) busy_run = cur_run;
      waiting        = 1;
      last_was_stall = 0;
    end else begin
      cur_run = 0;
      waiting = 0;
      if (branch_taken_i) begin
        flush_events++;
        last_was_stall = 0;
      end else if (load_use_i && !last_was_stall) begin
        stall_events++;
        last_was_stall = 1;
      end else begin
        last_was_stall = 0;
      end
    end
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic apply(input bit lu, input bit br, input bit busy);
    load_use_i     = lu;
    branch_taken_i = br;
    mem_busy_i     = busy;
    @(negedge clk);
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    load_use_i     = 1'b0;
    branch_taken_i = 1'b0;
    mem_busy_i     = 1'b0;
    model_reset();
    cur_run = 0;
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int burst;
    model_reset();
    cur_run = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Held load-use: stall, masked, stall again
    repeat (3) apply(1, 0, 0);
    apply(0, 0, 0);
    // Load-use together with redirect
    apply(1, 1, 0);
    apply(0, 0, 0);
    // Busy with pending load-use, then release
    repeat (5) apply(1, 0, 1);
    apply(1, 0, 0);
    apply(0, 0, 0);
    // Long busy: small instance times out, stays set afterwards
    repeat (6) apply(0, 0, 1);
    repeat (3) apply(0, 0, 0);
    // Five redirects saturate the small flush counter
    repeat (5) apply(0, 1, 0);
    apply(0, 0, 0);
    // Reset mid-wait and mid-stall
    repeat (3) apply(1, 0, 1);
    do_reset();
    apply(1, 0, 0);
    do_reset();
    apply(0, 0, 0);

    // Randomized traffic with occasional long busy bursts
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        burst = $urandom_range(1, 70);
        for (int j = 0; j < burst; j++) apply($urandom_range(0, 1), $urandom_range(0, 1), 1);
      end else begin
        apply($urandom_range(0, 2) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
